// File: rtl/swap_sort_ctrl.sv
// swap_sort_ctrl: loads N words, bubble-sorts them ascending (unsigned)
// with one shared compare-and-swap per clock, then streams them out.
// Ports: clk, rst_n (async, active-low); in_valid/in_data/in_ready
// producer side; out_valid/out_data/out_ready consumer side;
// busy (SORT or DRAIN), done (last word transfer), passes (last sort).
// Build option: define SWAP_SORT_EARLY_EXIT_EN to stop after the first
// pass with no swaps; otherwise every sort runs exactly N-1 passes.
module swap_sort_ctrl #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [6:0]   passes
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] LAST_PAIR = IW'(N - 2);
    localparam logic [6:0] PASS_LAST = 7'(N - 2);

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   bank_q [N];
    logic [W-1:0]   bank_d [N];
    logic [IW-1:0]  ld_idx_q, ld_idx_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic [IW-1:0]  pair_q, pair_d;
    logic [6:0]     pass_q, pass_d;
    logic           dirty_q, dirty_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           busy_q, busy_d;
    logic [6:0]     passes_q, passes_d;

    logic [IW-1:0]  pair_nx;
    logic [W-1:0]   lo_val;
    logic [W-1:0]   hi_val;
    logic           swap;
    logic           dirty_pass;
    logic           sort_exit;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        ld_idx_d    = ld_idx_q;
        rd_idx_d    = rd_idx_q;
        pair_d      = pair_q;
        pass_d      = pass_q;
        dirty_d     = dirty_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        passes_d    = passes_q;
        pair_nx     = pair_q + IW'(1);
        lo_val      = '0;
        hi_val      = '0;
        swap        = 1'b0;
        dirty_pass  = 1'b0;
        sort_exit   = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    bank_d[ld_idx_q] = in_data;
                    if (ld_idx_q == LAST) begin
                        state_d    = SORT;
                        ld_idx_d   = '0;
                        pair_d     = '0;
                        pass_d     = '0;
                        dirty_d    = 1'b0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        ld_idx_d = ld_idx_q + IW'(1);
                    end
                end
            end
            SORT: begin
                lo_val = bank_q[pair_q];
                hi_val = bank_q[pair_nx];
                swap   = lo_val > hi_val;
                if (swap) begin
                    bank_d[pair_q]  = hi_val;
                    bank_d[pair_nx] = lo_val;
                end
                // Dirty flag restarts at pair 0 so it covers one pass only.
                dirty_pass = ((pair_q == '0) ? 1'b0 : dirty_q) | swap;
                dirty_d    = dirty_pass;
                if (pair_q == LAST_PAIR) begin
                    pair_d    = '0;
                    pass_d    = pass_q + 7'd1;
                    sort_exit = (pass_q == PASS_LAST);
`ifdef SWAP_SORT_EARLY_EXIT_EN
                    sort_exit = sort_exit || !dirty_pass;
`endif
                    if (sort_exit) begin
                        state_d     = DRAIN;
                        passes_d    = pass_q + 7'd1;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    pair_d = pair_nx;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST) begin
                        state_d     = LOAD;
                        rd_idx_d    = '0;
                        ld_idx_d    = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Look ahead through this edge's swap so the first word is current.
        out_data_d = bank_d[rd_idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            for (int i = 0; i < N; i++) begin
                bank_q[i] <= '0;
            end
            ld_idx_q    <= '0;
            rd_idx_q    <= '0;
            pair_q      <= '0;
            pass_q      <= '0;
            dirty_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            passes_q    <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            ld_idx_q    <= ld_idx_d;
            rd_idx_q    <= rd_idx_d;
            pair_q      <= pair_d;
            pass_q      <= pass_d;
            dirty_q     <= dirty_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            passes_q    <= passes_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign passes    = passes_q;
    // Pulse coincides with the final handshake, so it follows out_ready.
    assign done      = out_valid_q && out_ready && (rd_idx_q == LAST);

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// tb_swap_sort_ctrl: randomized load/drain traffic for swap_sort_ctrl,
// checked against a whole-array sort model kept in the bench.
module tb_swap_sort_ctrl;

    localparam int N = 8;
    localparam int W = 8;

    typedef logic [W-1:0] vec_t [N];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         done;
    logic [6:0]   passes;

    int n_checks = 0;
    int n_errors = 0;
    int prev_p = 0;

    swap_sort_ctrl #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .passes(passes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sorted result plus the number of whole passes the sort should take.
    function automatic void model(input vec_t w, output vec_t s,
                                  output int p);
        vec_t a;
        logic [W-1:0] t;
        bit dirty;
        a = w;
        p = N - 1;
        for (int ps = 1; ps <= N - 1; ps++) begin
            dirty = 0;
            for (int j = 0; j < N - 1; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                    dirty = 1;
                end
            end
`ifdef SWAP_SORT_EARLY_EXIT_EN
            if (!dirty) begin
                p = ps;
                break;
            end
`endif
        end
        s = a;
    endfunction

    task automatic load(input vec_t w);
        int i = 0;
        int guard = 0;
        while (i < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data = W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data = w[i];
                if (in_ready) i++;
            end
        end
        check("load_count", i, N);
    endtask

    task automatic sort_phase(input int exp_p);
        int cyc = 0;
        int guard = 0;
        @(negedge clk);
        // A stray word offered during SORT must be ignored.
        in_valid = 1'b1;
        in_data = 8'hAA;
        check("in_ready_low", in_ready, 0);
        while (!out_valid && guard < 5000) begin
            if (busy) cyc++;
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("sort_done", out_valid, 1);
        check("sort_cycles", cyc, exp_p * (N - 1));
        check("passes", passes, exp_p);
        check("busy_drain", busy, 1);
    endtask

    task automatic drain(input vec_t s, input int stall_idx);
        int k = 0;
        int guard = 0;
        int hold = 0;
        while (k < N && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (k == stall_idx && hold < 3) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            check("out_valid", out_valid, 1);
            check("out_data", out_data, s[k]);
            check("done", done, out_ready && (k == N - 1));
            if (out_ready) k++;
        end
        check("drain_count", k, N);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    task automatic run_case(input vec_t w, input int stall_idx);
        vec_t s;
        int p;
        model(w, s, p);
        check("passes_held", passes, prev_p);
        load(w);
        sort_phase(p);
        drain(s, stall_idx);
        prev_p = p;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_passes"}, passes, 0);
    endtask

    initial begin
        vec_t v;
        repeat (2) @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");

        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        run_case(v, -1);
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_case(v, -1);
        v = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd5, 8'd0, 8'd255, 8'd1};
        run_case(v, 2);

        // Abort a sort part-way through with a one-cycle reset.
        v = '{8'd200, 8'd10, 8'd99, 8'd3, 8'd3, 8'd77, 8'd1, 8'd150};
        load(v);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("abort_busy", busy, 1);
            check("abort_done", done, 0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        prev_p = 0;
        v = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
        run_case(v, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                if (r % 2 == 0) v[i] = W'($urandom_range(0, 3));
                else v[i] = W'($urandom);
            end
            run_case(v, int'($urandom_range(0, N - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
